fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage upstream of the combinational instruction ROM. Owns the PC and drives
//  the ROM chip-enable and address. Registers the returned word into an IF/ID register with a
//  valid/ready handshake toward decode.
//  Handles jump redirects with IF/ID flush, and traps fetches past the end of ROM.
// PARAMETERS
//  XLEN      32      datapath/address width
//  MEM_SIZE  32      ROM size in bytes; legal fetch PCs are 0..MEM_SIZE-4
//  RESET_PC  'h0     PC loaded on reset (word aligned)
// PORTS
//  clk_i         in   1     clock, rising edge
//  rst_n_i       in   1     reset, asynchronous, active-low
//  rom_ce_o      out  1     ROM chip enable (ROM returns 0 when low)
//  rom_addr_o    out  XLEN  ROM byte address, always word aligned
//  rom_inst_i    in   XLEN  ROM instruction word, combinational from rom_addr_o
//  jump_i        in   1     redirect request, one cycle pulse
//  jump_addr_i   in   XLEN  redirect target; bits [1:0] ignored
//  id_ready_i    in   1     decode accepts IF/ID contents this cycle
//  id_valid_o    out  1     IF/ID holds a valid instruction
//  id_pc_o       out  XLEN  PC of the instruction in IF/ID
//  id_inst_o     out  XLEN  instruction in IF/ID, passed unchanged from ROM (byte order untouched)
//  fault_o       out  1     PC ran outside ROM; fetch halted
// BEHAVIOUR
//  - Reset (async, any time): state=S_BOOT; pc_q=RESET_PC; id_valid_o=0; id_pc_o=0; id_inst_o=0;
//    fault_o=0; rom_ce_o=0.
//  - rom_addr_o = pc_q.
//  - States: S_BOOT, S_RUN, S_FAULT.
//    - S_BOOT: lasts one cycle, ce low. Next state is S_RUN. jump_i here loads the target first.
//  - oob = (pc_q > MEM_SIZE-4), unsigned compare.
//  - room = !id_valid_o | id_ready_i.
//  - rom_ce_o = S_RUN & !oob & !jump_i & room.
//  - fire = rom_ce_o. On fire: id_valid_o<=1, id_pc_o<=pc_q, id_inst_o<=rom_inst_i, pc_q<=pc_q+4.
//    - pc_q+4 wraps modulo 2^XLEN.
//  - When id_ready_i=1 and there is no fire (and no jump), id_valid_o<=0.
//  - Stall: id_valid_o=1 and id_ready_i=0 -> IF/ID and pc_q are held and rom_ce_o=0.
//  - S_RUN with oob and no jump_i: go to S_FAULT; fault_o<=1. A valid IF/ID entry still drains
//    normally.
//  - S_FAULT: rom_ce_o=0; pc_q is held; fault_o stays 1. Left only by jump_i or reset.
//  - jump_i (any state; highest priority, overrides stall and fire):
//    - pc_q <= {jump_addr_i[XLEN-1:2],2'b00}.
//    - id_valid_o <= 0; the in-flight fetch is discarded.
//    - State goes to S_RUN and fault_o <= 0.
//    - An out-of-range target re-enters S_FAULT one cycle later.
//  - Latency: instruction at PC P is fetched in cycle N and shown on id_* from cycle N+1.
//    - Jump pulsed in cycle J: target is fetched in J+1, and id_valid_o=1 for it in J+2.
//  - Throughput: one instruction per cycle while id_ready_i=1.
//  - id_pc_o/id_inst_o keep their last values while id_valid_o=0.
// TESTING
//  1 Reset release, RESET_PC=0, id_ready_i=1, ROM words W0..W7 -> ce low first cycle, then
//    id_pc_o 0,4,8.. on consecutive cycles with id_inst_o=W0,W1,W2.
//  2 id_ready_i=0 for 3 cycles with id_pc_o=8 -> id_* held, rom_ce_o=0, rom_addr_o=0xC;
//    release -> next id_pc_o=0xC.
//  3 During the stall in test 2, jump_i=1 with jump_addr_i=0x13 -> id_valid_o=0 next cycle,
//    rom_addr_o=0x10, id_pc_o=0x10 valid two cycles after the jump.
//  4 MEM_SIZE=32, run sequentially -> last valid id_pc_o=0x1C, then fault_o=1, rom_ce_o=0,
//    no further valid entries.
//  5 In S_FAULT, jump to 0x4 -> fault_o=0 next cycle and fetch resumes at 0x4.
//    Jump to 0x40 instead -> fault_o=1 again one cycle later.
//  6 Drop rst_n_i mid-run between clock edges -> all outputs reach their reset values
//    immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage in front of a combinational instruction ROM.
// Owns the PC, drives the ROM chip enable/address, and holds the fetched word in an
// IF/ID register that decode drains with a valid/ready handshake. Jumps redirect the
// PC and flush IF/ID; running off the end of the ROM parks the stage in a fault state
// until the next jump or reset.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter int              MEM_SIZE = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic            rom_ce_o,
    output logic [XLEN-1:0] rom_addr_o,
    input  logic [XLEN-1:0] rom_inst_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            id_ready_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o,
    output logic            fault_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    // Highest PC that still addresses a full word inside the ROM.
    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_SIZE - 4);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic            oob;
    logic            room;
    logic            fire;
    logic [XLEN-1:0] jump_target;
    logic            jump_addr_unused;

    // Targets are forced to word alignment; the dropped low bits are intentionally unused.
    assign jump_target      = {jump_addr_i[XLEN-1:2], 2'b00};
    assign jump_addr_unused = ^jump_addr_i[1:0];

    // The IF/ID slot can take a new word if it is empty or being consumed this cycle.
    assign oob        = (pc_q > LAST_PC);
    assign room       = !id_valid_o || id_ready_i;
    assign fire       = (state_q == S_RUN) && !oob && !jump_i && room;
    assign rom_ce_o   = fire;
    assign rom_addr_o = pc_q;

    // PC, fetch FSM and IF/ID register; a jump overrides stall, fetch and fault.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            id_valid_o <= 1'b0;
            id_pc_o    <= '0;
            id_inst_o  <= '0;
            fault_o    <= 1'b0;
        end else if (jump_i) begin
            pc_q       <= jump_target;
            id_valid_o <= 1'b0;
            state_q    <= S_RUN;
            fault_o    <= 1'b0;
        end else begin
            if (fire) begin
                id_valid_o <= 1'b1;
                id_pc_o    <= pc_q;
                id_inst_o  <= rom_inst_i;
                pc_q       <= pc_q + XLEN'(4);
            end else if (id_ready_i) begin
                id_valid_o <= 1'b0;
            end

            case (state_q)
                S_BOOT: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (oob) begin
                        state_q <= S_FAULT;
                        fault_o <= 1'b1;
                    end
                end
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

endmodule
